// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand-fetch slice: datapath width,
// ALU operation codes, B-shift codes and the fetch FSM state encoding.
package alu_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_AND  = 2'b10,
        ALU_NOTB = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_SHL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ_A,
        ST_READ_B,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/alu_operand_fetch_if.sv
// Bundle of the register-file write port, the request handshake and the
// operand handshake toward the ALU. The block under design is the slave.
interface alu_operand_fetch_if #(
    parameter int DATA_W = alu_pkg::DATA_W
);

    logic              wr_en;
    logic [2:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              req_valid;
    logic              req_ready;
    logic [2:0]        readA;
    logic [2:0]        readB;
    logic [1:0]        shift;
    logic              asel;
    logic              bsel;
    logic [DATA_W-1:0] sximm5;
    logic [1:0]        alu_op_in;

    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] Ain;
    logic [DATA_W-1:0] Bin;
    logic [1:0]        ALUop;

    modport master (
        output wr_en, wr_addr, wr_data,
        output req_valid, readA, readB, shift, asel, bsel, sximm5, alu_op_in,
        output op_ready,
        input  req_ready, op_valid, Ain, Bin, ALUop
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  req_valid, readA, readB, shift, asel, bsel, sximm5, alu_op_in,
        input  op_ready,
        output req_ready, op_valid, Ain, Bin, ALUop
    );

endinterface

// File: rtl/regfile8.sv
// Eight-entry register file with one combinational read port and one
// synchronous write port. Reads return the pre-edge contents, so a capture
// on the same edge as a write to that register sees the old value.
module regfile8 #(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [2:0]        i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [2:0]        i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [8];

    // Register storage: cleared on reset, written on the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage: accepts a request, reads A then B through the single
// register-file read port, and presents Ain/Bin/ALUop in HOLD until the ALU
// consumes them.
module alu_operand_fetch #(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_operand_fetch_if.slave bus
);

    import alu_pkg::*;

    state_e            r_state;
    state_e            w_next;
    logic              w_accept;

    logic [2:0]        r_read_a;
    logic [2:0]        r_read_b;
    shift_e            r_shift;
    logic              r_asel;
    logic              r_bsel;
    logic [DATA_W-1:0] r_sximm5;
    aluop_e            r_aluop;

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_ain;
    logic [DATA_W-1:0] r_bin;
    aluop_e            r_aluop_out;

    logic [2:0]        w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_b_shifted;

    assign w_rd_addr = (r_state == ST_READ_B) ? r_read_b : r_read_a;

    regfile8 #(.DATA_W(DATA_W)) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (bus.wr_en),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = bus.req_valid;
                if (bus.req_valid) begin
                    w_next = ST_READ_A;
                end
            end
            ST_READ_A: w_next = ST_READ_B;
            ST_READ_B: w_next = ST_HOLD;
            ST_HOLD: begin
                if (bus.op_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request fields latched at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_a <= '0;
            r_read_b <= '0;
            r_shift  <= SH_NONE;
            r_asel   <= 1'b0;
            r_bsel   <= 1'b0;
            r_sximm5 <= '0;
            r_aluop  <= ALU_ADD;
        end else if (w_accept) begin
            r_read_a <= bus.readA;
            r_read_b <= bus.readB;
            r_shift  <= shift_e'(bus.shift);
            r_asel   <= bus.asel;
            r_bsel   <= bus.bsel;
            r_sximm5 <= bus.sximm5;
            r_aluop  <= aluop_e'(bus.alu_op_in);
        end
    end

    // B shifter on the register-file read data.
    always_comb begin
        w_b_shifted = w_rd_data;
        case (r_shift)
            SH_SHL1: w_b_shifted = {w_rd_data[DATA_W-2:0], 1'b0};
            SH_LSR1: w_b_shifted = {1'b0, w_rd_data[DATA_W-1:1]};
            SH_ASR1: w_b_shifted = {w_rd_data[DATA_W-1], w_rd_data[DATA_W-1:1]};
            default: w_b_shifted = w_rd_data;
        endcase
    end

    // A register captures R[readA] on leaving READ_A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
        end else if (r_state == ST_READ_A) begin
            r_a <= w_rd_data;
        end
    end

    // Output registers load on leaving READ_B so Ain/Bin/ALUop stay frozen
    // through IDLE/READ_A/READ_B; the B capture goes straight through the
    // shifter/immediate select into Bin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ain       <= '0;
            r_bin       <= '0;
            r_aluop_out <= ALU_ADD;
        end else if (r_state == ST_READ_B) begin
            r_ain       <= r_asel ? '0 : r_a;
            r_bin       <= r_bsel ? r_sximm5 : w_b_shifted;
            r_aluop_out <= r_aluop;
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.op_valid  = (r_state == ST_HOLD);
    assign bus.Ain       = r_ain;
    assign bus.Bin       = r_bin;
    assign bus.ALUop     = r_aluop_out;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed bench for alu_operand_fetch: a transaction-level reference model
// tracks the register file and each request, a compare process checks every
// cycle, and literal expectations pin the directed scenarios.
module tb_alu_operand_fetch;

    localparam int W = 16;
    localparam logic [W-1:0] MSB = {1'b1, {(W-1){1'b0}}};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    alu_operand_fetch_if #(.DATA_W(W)) bus ();

    alu_operand_fetch #(.DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference shift on a plain value.
    function automatic logic [W-1:0] shift_model(input logic [W-1:0] b, input logic [1:0] sh);
        logic [W-1:0] r;
        case (sh)
            2'd1:    r = b + b;
            2'd2:    r = b / 2;
            2'd3:    r = (b / 2) | (b & MSB);
            default: r = b;
        endcase
        return r;
    endfunction

    // Model: registers, one outstanding request and its age in cycles.
    logic [W-1:0] m_mem [8];
    int           m_age   = -1;
    logic [2:0]   m_ra    = '0;
    logic [2:0]   m_rb    = '0;
    logic [1:0]   m_sh    = '0;
    logic [1:0]   m_op    = '0;
    logic         m_as    = 1'b0;
    logic         m_bs    = 1'b0;
    logic [W-1:0] m_imm   = '0;
    logic [W-1:0] m_a     = '0;
    logic [W-1:0] m_ain   = '0;
    logic [W-1:0] m_bin   = '0;
    logic [1:0]   m_aluop = '0;

    // Model update on each clock (reads see pre-edge register contents).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_mem[i] <= '0;
            m_age   <= -1;
            m_a     <= '0;
            m_ain   <= '0;
            m_bin   <= '0;
            m_aluop <= '0;
        end else begin
            if (bus.wr_en) m_mem[bus.wr_addr] <= bus.wr_data;
            if (m_age < 0) begin
                if (bus.req_valid) begin
                    m_ra  <= bus.readA;
                    m_rb  <= bus.readB;
                    m_sh  <= bus.shift;
                    m_as  <= bus.asel;
                    m_bs  <= bus.bsel;
                    m_imm <= bus.sximm5;
                    m_op  <= bus.alu_op_in;
                    m_age <= 0;
                end
            end else if (m_age == 0) begin
                m_a   <= m_mem[m_ra];
                m_age <= 1;
            end else if (m_age == 1) begin
                m_ain   <= m_as ? '0 : m_a;
                m_bin   <= m_bs ? m_imm : shift_model(m_mem[m_rb], m_sh);
                m_aluop <= m_op;
                m_age   <= 2;
            end else if (bus.op_ready) begin
                m_age <= -1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always begin
        @(posedge clk);
        #1;
        if (chk_en && rst_n) begin
            check("cyc_op_valid",  bus.op_valid,  (m_age == 2));
            check("cyc_req_ready", bus.req_ready, (m_age < 0));
            check("cyc_Ain",       bus.Ain,       m_ain);
            check("cyc_Bin",       bus.Bin,       m_bin);
            check("cyc_ALUop",     bus.ALUop,     m_aluop);
        end
    end

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    // Presents a request for one cycle; returns at the negedge in READ_A.
    task automatic do_req(input logic [2:0] ra, input logic [2:0] rb, input logic [1:0] sh,
                          input logic as, input logic bs, input logic [W-1:0] imm,
                          input logic [1:0] op);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.readA     = ra;
        bus.readB     = rb;
        bus.shift     = sh;
        bus.asel      = as;
        bus.bsel      = bs;
        bus.sximm5    = imm;
        bus.alu_op_in = op;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 0; i <= 10; i++) begin
            if (bus.op_valid === 1'b1) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) check("op_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_ops();
        bus.op_ready = 1'b1;
        @(negedge clk);
        bus.op_ready = 1'b0;
        check("ready_after_release", bus.req_ready, 1'b1);
    endtask

    logic [W-1:0] exp_sh [3];
    int lat;

    initial begin
        exp_sh[0] = 16'h0008;
        exp_sh[1] = 16'h4002;
        exp_sh[2] = 16'hC002;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.req_valid = 1'b0; bus.readA = '0; bus.readB = '0; bus.shift = '0;
        bus.asel = 1'b0; bus.bsel = 1'b0; bus.sximm5 = '0; bus.alu_op_in = '0;
        bus.op_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_op_valid",  bus.op_valid,  1'b0);
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_Ain",       bus.Ain,       16'h0000);
        check("rst_Bin",       bus.Bin,       16'h0000);
        check("rst_ALUop",     bus.ALUop,     2'b00);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Basic fetch and latency.
        wr(3'd1, 16'd6);
        wr(3'd2, 16'd4);
        do_req(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00);
        wait_valid(lat);
        check("latency",     lat,       32'd2);
        check("basic_Ain",   bus.Ain,   16'd6);
        check("basic_Bin",   bus.Bin,   16'd4);
        check("basic_ALUop", bus.ALUop, 2'b00);
        check("model_Ain",   m_ain,     16'd6);
        check("model_Bin",   m_bin,     16'd4);
        release_ops();

        // Shift codes on a value with MSB and low bits set.
        wr(3'd3, 16'h8004);
        for (int s = 1; s <= 3; s++) begin
            do_req(3'd3, 3'd3, 2'(s), 1'b0, 1'b0, 16'h0000, 2'(s));
            wait_valid(lat);
            check("shift_Bin",   bus.Bin,   exp_sh[s-1]);
            check("shift_Ain",   bus.Ain,   16'h8004);
            check("shift_ALUop", bus.ALUop, 32'(s));
            check("model_shift", m_bin,     exp_sh[s-1]);
            release_ops();
        end

        // Zero A and immediate B.
        do_req(3'd1, 3'd2, 2'b00, 1'b1, 1'b1, 16'hFFFB, 2'b11);
        wait_valid(lat);
        check("imm_Ain",   bus.Ain,   16'h0000);
        check("imm_Bin",   bus.Bin,   16'hFFFB);
        check("imm_ALUop", bus.ALUop, 2'b11);
        release_ops();

        // Back-pressure: HOLD with op_ready low for 5 cycles.
        do_req(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b01);
        wait_valid(lat);
        repeat (5) begin
            @(negedge clk);
            check("hold_op_valid",  bus.op_valid,  1'b1);
            check("hold_req_ready", bus.req_ready, 1'b0);
            check("hold_Ain",       bus.Ain,       16'd6);
            check("hold_Bin",       bus.Bin,       16'd4);
        end
        release_ops();
        check("idle_op_valid", bus.op_valid, 1'b0);

        // Write to R[readB] during READ_A is seen by the B capture.
        do_req(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b10);
        bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 16'd9;
        @(negedge clk);
        bus.wr_en = 1'b0;
        wait_valid(lat);
        check("wr_readA_Bin", bus.Bin, 16'd9);
        check("wr_readA_Ain", bus.Ain, 16'd6);
        release_ops();

        // Write to R[readA] on the A-capture edge: old value captured.
        do_req(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00);
        bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 16'd7;
        @(negedge clk);
        bus.wr_en = 1'b0;
        wait_valid(lat);
        check("same_edge_Ain", bus.Ain, 16'd6);
        check("same_edge_Bin", bus.Bin, 16'd9);
        release_ops();

        do_req(3'd1, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00);
        wait_valid(lat);
        check("new_R1_Ain", bus.Ain, 16'd7);
        check("new_R1_Bin", bus.Bin, 16'd7);
        release_ops();

        // Reset during READ_B abandons the request and clears registers.
        do_req(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b01);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_op_valid",  bus.op_valid,  1'b0);
        check("midrst_req_ready", bus.req_ready, 1'b1);
        check("midrst_Ain",       bus.Ain,       16'h0000);
        check("midrst_Bin",       bus.Bin,       16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("postrst_no_valid", bus.op_valid, 1'b0);
        end
        do_req(3'd1, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00);
        wait_valid(lat);
        check("postrst_R1_Ain", bus.Ain, 16'h0000);
        check("postrst_R1_Bin", bus.Bin, 16'h0000);
        release_ops();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_fetch.md
ALU_OPERAND_FETCH -- requirements
Module: alu_operand_fetch

Interface
REQ-001 Parameter: DATA_W, default 16, datapath width of registers and operands.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 wr_en  in  1  register-file write strobe.
REQ-005 wr_addr  in  3  register-file write index R0..R7.
REQ-006 wr_data  in  DATA_W  register-file write data.
REQ-007 req_valid  in  1  operand-fetch request present.
REQ-008 req_ready  out  1  block accepts a request this cycle.
REQ-009 readA, readB  in  3 each  source register indices.
REQ-010 shift  in  2  B shift code: 00 none, 01 shl1, 10 lsr1, 11 asr1.
REQ-011 asel, bsel  in  1 each  asel=1 forces Ain=0; bsel=1 selects sximm5 for Bin.
REQ-012 sximm5  in  DATA_W  sign-extended immediate.
REQ-013 alu_op_in  in  2  ALU operation code, carried with the request.
REQ-014 op_valid  out  1  Ain/Bin/ALUop valid for the downstream ALU.
REQ-015 op_ready  in  1  downstream ALU consumes operands.
REQ-016 Ain, Bin  out  DATA_W each  ALU operands; ALUop  out  2  latched operation.

Function
REQ-017 Register file: 8 x DATA_W; one read port, one write port; write occurs at rising edge when wr_en=1.
REQ-018 FSM states IDLE, READ_A, READ_B, HOLD; req_ready=1 only in IDLE.
REQ-019 IDLE -> READ_A on req_valid&req_ready; at that edge latch readA, readB, shift, asel, bsel, sximm5, alu_op_in.
REQ-020 READ_A -> READ_B unconditionally; A register captures R[readA] at the leaving edge.
REQ-021 READ_B -> HOLD unconditionally; B register captures R[readB] at the leaving edge.
REQ-022 HOLD: op_valid=1; HOLD -> IDLE on op_ready=1; otherwise remain with outputs stable.
REQ-023 Latency: request accepted at edge T gives op_valid=1 in the cycle after edge T+2; minimum request spacing 4 cycles.
REQ-024 Ain = asel ? 0 : A; Bin = bsel ? sximm5 : shift(B); outputs derive only from latched values.
REQ-025 shl1 fills LSB with 0; lsr1 fills MSB with 0; asr1 replicates B[DATA_W-1]; bits shifted out are discarded.
REQ-026 Write to the register being read in the same cycle: the capture takes the old value; no forwarding.
REQ-027 Writes are accepted in every state; a write to R[readB] during READ_A is visible to the READ_B capture.
REQ-028 op_valid=0 in IDLE, READ_A and READ_B; Ain, Bin and ALUop hold their last values there.

Reset
REQ-029 rst_n=0 immediately forces state=IDLE, op_valid=0, req_ready=1, A=B=0, all latched fields 0, and R0..R7=0.
REQ-030 Reset mid-operation abandons the request; no op_valid is produced for it.
REQ-031 Reset outputs: Ain=0, Bin=0, ALUop=00.

Structure
REQ-032 Shared package alu_pkg holds DATA_W, the ALUop encoding (ADD, SUB, AND, NOTB), the shift-code encoding and the FSM state enum.
REQ-033 Register file is a sub-module named regfile8; the FSM, operand registers and shifter stay in alu_operand_fetch.

Verification
REQ-034 Write R1=6, R2=4; request readA=1, readB=2, shift=00, ALUop=00 -> op_valid three cycles after acceptance; Ain=6, Bin=4, ALUop=00.
REQ-035 Write R3=16'h8004; readB=3 with shift=01, 10 and 11 in turn -> Bin=16'h0008, 16'h4002 and 16'hC002.
REQ-036 asel=1, bsel=1, sximm5=16'hFFFB -> Ain=0, Bin=16'hFFFB.
REQ-037 Hold op_ready=0 for 5 cycles in HOLD -> op_valid, Ain and Bin stay stable and req_ready=0; op_ready=1 -> IDLE the next cycle.
REQ-038 Write R2=9 during READ_A with readB=2 (old value 4) -> Bin=9; write R1=7 in the same cycle as the READ_A capture of R1 (old value 6) -> Ain=6.
REQ-039 Assert rst_n=0 during READ_B -> op_valid=0 and state=IDLE at once; a subsequent read of R1 returns 0.
